multicycle_seq: RTL and testbench

Multi-cycle sequencer for the RV32I core. It time-shares one single-port memory between instruction fetch and load/store data access. It steps the datapath through FETCH, DECODE, EXEC, MEM and WB using the decoder's control outputs, and it handles memory handshakes, bus timeouts, illegal-instruction trapping and the retired-instruction count.

---
 rtl/multicycle_seq_if.sv | 42 ++++
 rtl/multicycle_seq.sv | 133 +++++++++++++
 tb/tb_multicycle_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_seq_if.sv
// Sequencer <-> datapath/decoder/memory bundle; master = sequencer side.
// Memory handshake is req-held-until-ack, with no separate ready signal.
interface multicycle_seq_if #(
  parameter int CNT_W = 32
);
  logic             i_insn_vld;
  logic             i_reg_we;
  logic             i_mem_re;
  logic             i_mem_we;
  logic             i_pc_src_branch;
  logic             i_pc_src_jal;
  logic             i_pc_src_jalr;
  logic             i_br_taken;
  logic             i_mem_ack;
  logic             o_mem_req;
  logic             o_mem_we;
  logic             o_mem_addr_sel;
  logic             o_ir_we;
  logic             o_mdr_we;
  logic             o_rf_we;
  logic             o_pc_we;
  logic [1:0]       o_pc_sel;
  logic             o_retire;
  logic [CNT_W-1:0] o_instret;
  logic             o_halt;
  logic [1:0]       o_trap_cause;
  logic [2:0]       o_state;

  modport master (
    input  i_insn_vld, i_reg_we, i_mem_re, i_mem_we, i_pc_src_branch,
           i_pc_src_jal, i_pc_src_jalr, i_br_taken, i_mem_ack,
    output o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_we, o_mdr_we, o_rf_we,
           o_pc_we, o_pc_sel, o_retire, o_instret, o_halt, o_trap_cause, o_state
  );

  modport slave (
    output i_insn_vld, i_reg_we, i_mem_re, i_mem_we, i_pc_src_branch,
           i_pc_src_jal, i_pc_src_jalr, i_br_taken, i_mem_ack,
    input  o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_we, o_mdr_we, o_rf_we,
           o_pc_we, o_pc_sel, o_retire, o_instret, o_halt, o_trap_cause, o_state
  );
endinterface

// File: rtl/multicycle_seq.sv
// RV32I multi-cycle sequencer sharing one memory port between fetch and data.
// 4 cycles ALU/jump, 5 load/store at zero wait; memory stalls hold req until ack or timeout.
module multicycle_seq #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  multicycle_seq_if.master  bus
);
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [1:0]       cause_q, cause_d;
  logic             tmo_expire;

  logic       mem_req, mem_we, addr_sel, ir_we, mdr_we, rf_we, pc_we, retire, halt;
  logic [1:0] pc_sel;

  // Expiry is judged on the cycle that would bring the wait count to TIMEOUT.
  assign tmo_expire = (TIMEOUT > 0) && (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_FETCH;
      tmo_q     <= '0;
      instret_q <= '0;
      cause_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = '0;
    instret_d = instret_q;
    cause_d   = cause_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    mdr_we    = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    retire    = 1'b0;
    halt      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.i_mem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_expire) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DECODE: begin
        if (!bus.i_insn_vld) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = (bus.i_mem_re || bus.i_mem_we) ? S_MEM : S_WB;
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = bus.i_mem_we;
        if (bus.i_mem_ack) begin
          mdr_we  = bus.i_mem_re && !bus.i_mem_we;
          state_d = S_WB;
        end else if (tmo_expire) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WB: begin
        rf_we     = bus.i_reg_we;
        pc_we     = 1'b1;
        retire    = 1'b1;
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
        if (bus.i_pc_src_jalr)
          pc_sel = 2'b10;
        else if (bus.i_pc_src_jal || (bus.i_pc_src_branch && bus.i_br_taken))
          pc_sel = 2'b01;
      end
      S_TRAP: halt = 1'b1;
      default: begin
        state_d = S_TRAP;
        cause_d = 2'd2;
      end
    endcase
  end

  // Reset masks every output combinationally so an in-flight request drops at once.
  assign bus.o_mem_req      = !i_reset && mem_req;
  assign bus.o_mem_we       = !i_reset && mem_we;
  assign bus.o_mem_addr_sel = !i_reset && addr_sel;
  assign bus.o_ir_we        = !i_reset && ir_we;
  assign bus.o_mdr_we       = !i_reset && mdr_we;
  assign bus.o_rf_we        = !i_reset && rf_we;
  assign bus.o_pc_we        = !i_reset && pc_we;
  assign bus.o_pc_sel       = i_reset ? 2'b00 : pc_sel;
  assign bus.o_retire       = !i_reset && retire;
  assign bus.o_instret      = i_reset ? '0 : instret_q;
  assign bus.o_halt         = !i_reset && halt;
  assign bus.o_trap_cause   = i_reset ? 2'd0 : cause_q;
  assign bus.o_state        = i_reset ? 3'd0 : state_q;
endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq: a vector table of instructions with a reactive
// memory model, plus hand-written timeout, illegal-instruction and reset sequences.
module tb_multicycle_seq;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  logic [CNT_W-1:0] exp_instret = '0;

  multicycle_seq_if #(.CNT_W(CNT_W)) bus ();

  multicycle_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ctl;    // {vld, reg_we, re, we, branch, jal, jalr, taken}
    int          fwait;
    int          mwait;
    int          cycles;
    logic [63:0] seq;
    logic        rf;
    logic [1:0]  psel;
    logic        memwe;
    logic        mdr;
    int          mreq;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] all_outs();
    return {bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr_sel, bus.o_ir_we, bus.o_mdr_we,
            bus.o_rf_we, bus.o_pc_we, bus.o_pc_sel, bus.o_retire, bus.o_instret,
            bus.o_halt, bus.o_trap_cause, bus.o_state};
  endfunction

  task automatic set_dec(input logic [7:0] ctl);
    {bus.i_insn_vld, bus.i_reg_we, bus.i_mem_re, bus.i_mem_we,
     bus.i_pc_src_branch, bus.i_pc_src_jal, bus.i_pc_src_jalr, bus.i_br_taken} = ctl;
  endtask

  // Called and returns just after a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    bus.i_mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_instret = '0;
  endtask

  task automatic run_insn(input string tag, input vec_t v);
    int cyc = 0, fw = 0, mw = 0, mreq = 0, fbad = 0, ret = 0, pcw = 0;
    logic [63:0] seq = '0;
    logic a_rf = 1'b0, a_memwe = 1'b0, a_mdr = 1'b0;
    logic [1:0] a_psel = 2'b11;
    logic [2:0] st;
    bit done = 1'b0;
    set_dec(v.ctl);
    while (!done && cyc < 60) begin
      st = bus.o_state;
      bus.i_mem_ack = 1'b0;
      if (st == 3'd0) begin
        bus.i_mem_ack = (fw == v.fwait);
        fw++;
      end else if (st == 3'd3) begin
        bus.i_mem_ack = (mw == v.mwait);
        mw++;
      end
      #1;
      cyc++;
      seq = {seq[59:0], 1'b0, st};
      if (bus.o_retire) ret++;
      if (bus.o_pc_we) pcw++;
      if (st == 3'd0 && (bus.o_mem_req !== 1'b1 || bus.o_mem_addr_sel !== 1'b0 ||
                         bus.o_mem_we !== 1'b0 || bus.o_ir_we !== bus.i_mem_ack)) fbad++;
      if (st == 3'd3) begin
        if (bus.o_mem_we) a_memwe = 1'b1;
        if (bus.o_mdr_we) a_mdr = 1'b1;
        if (bus.o_mem_req && bus.o_mem_addr_sel) mreq++;
      end
      if (st == 3'd4) begin
        a_rf   = bus.o_rf_we;
        a_psel = bus.o_pc_sel;
        done   = 1'b1;
      end
      if (st == 3'd5) break;
      @(negedge clk);
    end
    bus.i_mem_ack = 1'b0;
    if (done) exp_instret = exp_instret + 1'b1;
    chk({tag, " cycles"}, 64'(cyc), 64'(v.cycles));
    chk({tag, " states"}, seq, v.seq);
    chk({tag, " rf_we"}, 64'(a_rf), 64'(v.rf));
    chk({tag, " pc_sel"}, 64'(a_psel), 64'(v.psel));
    chk({tag, " mem_we"}, 64'(a_memwe), 64'(v.memwe));
    chk({tag, " mdr_we"}, 64'(a_mdr), 64'(v.mdr));
    chk({tag, " data_req_cycles"}, 64'(mreq), 64'(v.mreq));
    chk({tag, " fetch_strobes_bad"}, 64'(fbad), 64'd0);
    chk({tag, " retire_pulses"}, 64'(ret), 64'd1);
    chk({tag, " pc_we_pulses"}, 64'(pcw), 64'd1);
    chk({tag, " instret"}, 64'(bus.o_instret), 64'(exp_instret));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fcnt;
    int bad;
    vecs[0]  = '{8'b1100_0000, 0,  0, 4,  64'h124,    1'b1, 2'b00, 1'b0, 1'b0, 0}; // ADDI
    vecs[1]  = '{8'b1110_0000, 0,  2, 7,  64'h123334, 1'b1, 2'b00, 1'b0, 1'b1, 3}; // LW, 2 waits
    vecs[2]  = '{8'b1001_0000, 0,  0, 5,  64'h1234,   1'b0, 2'b00, 1'b1, 1'b0, 1}; // SW
    vecs[3]  = '{8'b1000_1001, 0,  0, 4,  64'h124,    1'b0, 2'b01, 1'b0, 1'b0, 0}; // BEQ taken
    vecs[4]  = '{8'b1000_1000, 0,  0, 4,  64'h124,    1'b0, 2'b00, 1'b0, 1'b0, 0}; // BEQ not taken
    vecs[5]  = '{8'b1100_0100, 0,  0, 4,  64'h124,    1'b1, 2'b01, 1'b0, 1'b0, 0}; // JAL
    vecs[6]  = '{8'b1100_0010, 0,  0, 4,  64'h124,    1'b1, 2'b10, 1'b0, 1'b0, 0}; // JALR
    vecs[7]  = '{8'b1100_0110, 0,  0, 4,  64'h124,    1'b1, 2'b10, 1'b0, 1'b0, 0}; // JALR beats JAL
    vecs[8]  = '{8'b1100_0000, 3,  0, 7,  64'h124,    1'b1, 2'b00, 1'b0, 1'b0, 0}; // fetch 3 waits
    vecs[9]  = '{8'b1011_0000, 0,  1, 6,  64'h12334,  1'b0, 2'b00, 1'b1, 1'b0, 2}; // re+we: store wins
    vecs[10] = '{8'b1100_0000, 15, 0, 19, 64'h124,    1'b1, 2'b00, 1'b0, 1'b0, 0}; // ack on 16th cycle
    vecs[11] = '{8'b1100_0001, 0,  0, 4,  64'h124,    1'b1, 2'b00, 1'b0, 1'b0, 0}; // taken, no branch

    rst = 1'b1;
    bus.i_mem_ack = 1'b0;
    set_dec(8'h00);
    repeat (2) @(negedge clk);
    #1;
    chk("reset outputs", 64'(all_outs()), 64'd0);
    rst = 1'b0;
    #1;
    chk("post-reset state", 64'(bus.o_state), 64'd0);
    chk("post-reset mem_req", 64'(bus.o_mem_req), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_insn($sformatf("vec%0d", i), vecs[i]);

    // Counter wrap: retire until the model sits at all-ones, then once more.
    while (exp_instret != {CNT_W{1'b1}}) run_insn("fill", vecs[0]);
    run_insn("wrap", vecs[0]);
    chk("instret wrapped", 64'(bus.o_instret), 64'd0);

    // Fetch timeout: 16 cycles without ack.
    do_reset();
    fcnt = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      bus.i_mem_ack = 1'b0;
      #1;
      if (bus.o_state == 3'd0 && bus.o_mem_req) fcnt++;
      @(negedge clk);
    end
    #1;
    chk("tmo fetch cycles", 64'(fcnt), 64'(TIMEOUT));
    chk("tmo state", 64'(bus.o_state), 64'd5);
    chk("tmo halt", 64'(bus.o_halt), 64'd1);
    chk("tmo cause", 64'(bus.o_trap_cause), 64'd1);
    chk("tmo mem_req", 64'(bus.o_mem_req), 64'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.i_mem_ack = 1'b1;
      #1;
      if (bus.o_state != 3'd5 || bus.o_mem_req || bus.o_ir_we || bus.o_trap_cause != 2'd1) bad++;
    end
    chk("trap sticky", 64'(bad), 64'd0);
    @(negedge clk);

    // Illegal instruction trapped from DECODE.
    do_reset();
    set_dec(8'b0100_0000);
    bus.i_mem_ack = 1'b1;
    #1;
    chk("ill ir_we", 64'(bus.o_ir_we), 64'd1);
    @(negedge clk);
    bus.i_mem_ack = 1'b0;
    #1;
    chk("ill decode state", 64'(bus.o_state), 64'd1);
    bad = int'(bus.o_rf_we | bus.o_pc_we | bus.o_retire);
    @(negedge clk);
    #1;
    chk("ill trap state", 64'(bus.o_state), 64'd5);
    chk("ill cause", 64'(bus.o_trap_cause), 64'd2);
    chk("ill halt", 64'(bus.o_halt), 64'd1);
    for (int i = 0; i < 3; i++) begin
      bad += int'(bus.o_rf_we | bus.o_pc_we | bus.o_retire);
      @(negedge clk);
      #1;
    end
    chk("ill no strobes", 64'(bad), 64'd0);
    chk("ill instret", 64'(bus.o_instret), 64'(exp_instret));
    @(negedge clk);

    // Reset in the middle of a stalled load.
    do_reset();
    run_insn("pre", vecs[0]);
    set_dec(vecs[1].ctl);
    bus.i_mem_ack = 1'b1;
    @(negedge clk);
    bus.i_mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (!(bus.o_state == 3'd3 && bus.o_mem_req && bus.o_mem_addr_sel)) bad++;
      @(negedge clk);
    end
    chk("mid mem waiting", 64'(bad), 64'd0);
    rst = 1'b1;
    #1;
    chk("mid mem reset outputs", 64'(all_outs()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid mem after state", 64'(bus.o_state), 64'd0);
    chk("mid mem after instret", 64'(bus.o_instret), 64'd0);
    chk("mid mem after req", 64'(bus.o_mem_req), 64'd1);
    chk("mid mem after addr_sel", 64'(bus.o_mem_addr_sel), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
